// File: rtl/svm_pkg.sv
// svm_pkg: constants and helpers shared by the SVM kernel and vote stages.
//   svm_state_e   : vote-stage FSM encoding (IDLE, VOTE, ARGMAX, DONE)
//   svm_clog2     : ceiling log2, used for class-index and counter widths
//   svm_dec_count : one-vs-one decision count, C*(C-1)/2
//   svm_idx_width : index width that never collapses to zero bits
package svm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTE   = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } svm_state_e;

    function automatic int svm_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int svm_dec_count(input int class_count);
        return class_count * (class_count - 1) / 2;
    endfunction

    function automatic int svm_idx_width(input int count);
        return (count > 1) ? svm_clog2(count) : 1;
    endfunction

endpackage

// File: rtl/svm_pair_counter.sv
// svm_pair_counter: walks the one-vs-one class pairs (i,j), i<j, i outer,
// together with the running decision index d.
//   clk, reset : clock, synchronous active-high reset
//   i_clear    : restart at (0,1), d=0
//   i_step     : advance to the next pair
//   o_i, o_j   : current class pair
//   o_d        : current decision index
//   o_last     : current pair is the final decision
module svm_pair_counter
    import svm_pkg::*;
#(
    parameter int CLASS_COUNT = 3,
    parameter int CLASS_WIDTH = svm_clog2(CLASS_COUNT),
    parameter int DEC_WIDTH   = svm_idx_width(svm_dec_count(CLASS_COUNT))
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_step,
    output logic [CLASS_WIDTH-1:0] o_i,
    output logic [CLASS_WIDTH-1:0] o_j,
    output logic [DEC_WIDTH-1:0]   o_d,
    output logic                   o_last
);

    localparam int DEC_COUNT = svm_dec_count(CLASS_COUNT);

    logic [CLASS_WIDTH-1:0] r_i;
    logic [CLASS_WIDTH-1:0] r_j;
    logic [DEC_WIDTH-1:0]   r_d;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_i <= '0;
            r_j <= CLASS_WIDTH'(1);
            r_d <= '0;
        end else if (i_step) begin
            // j wraps to i+2 when the inner loop finishes; the step past the
            // last pair may truncate, but the owner has stopped stepping by then.
            if (r_j == CLASS_WIDTH'(CLASS_COUNT - 1)) begin
                r_i <= r_i + CLASS_WIDTH'(1);
                r_j <= r_i + CLASS_WIDTH'(2);
            end else begin
                r_j <= r_j + CLASS_WIDTH'(1);
            end
            r_d <= r_d + DEC_WIDTH'(1);
        end
    end

    assign o_i    = r_i;
    assign o_j    = r_j;
    assign o_d    = r_d;
    assign o_last = (r_d == DEC_WIDTH'(DEC_COUNT - 1));

endmodule

// File: rtl/svm_vote.sv
// svm_vote: one-vs-one SVM voting. Latches a vector of decision distances
// and biases, casts one vote per decision (one per cycle), then scans the
// classes (one per cycle) for the most-voted, lowest index on ties.
//   clk, reset    : clock, synchronous active-high reset
//   i_distance    : packed signed distances, decision d at [DIST_WIDTH*d +: DIST_WIDTH]
//   i_rho         : packed signed biases, same layout, latched with i_distance
//   i_dist_valid  : input vector valid
//   o_dist_ready  : ready for a vector (IDLE only)
//   o_res_class   : winning class
//   o_res_valid   : result valid, held until i_res_ready
//   i_res_ready   : consumer accepts the result
//   o_res_tie     : maximum shared by several classes (only with SVM_VOTE_TIE_EN)
//
// state  | meaning
// IDLE   | waiting for a vector
// VOTE   | one decision per cycle, vote to i if margin > 0, else j
// ARGMAX | one class per cycle, keep first strictly greater count
// DONE   | result presented until accepted
module svm_vote
    import svm_pkg::*;
#(
    parameter int  CLASS_COUNT = 3,
    parameter int  DIST_WIDTH  = 32,
    parameter int  CLASS_WIDTH = svm_clog2(CLASS_COUNT),
    localparam int DEC_COUNT   = svm_dec_count(CLASS_COUNT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DIST_WIDTH*DEC_COUNT-1:0] i_distance,
    input  logic [DIST_WIDTH*DEC_COUNT-1:0] i_rho,
    input  logic                            i_dist_valid,
    output logic                            o_dist_ready,
    output logic [CLASS_WIDTH-1:0]          o_res_class,
    output logic                            o_res_valid,
    input  logic                            i_res_ready
`ifdef SVM_VOTE_TIE_EN
   ,output logic                            o_res_tie
`endif
);

    localparam int DEC_WIDTH = svm_idx_width(DEC_COUNT);

    svm_state_e                      r_state;
    svm_state_e                      w_next_state;
    logic                            w_accept;
    logic [DIST_WIDTH*DEC_COUNT-1:0] r_dist;
    logic [DIST_WIDTH*DEC_COUNT-1:0] r_rho;
    logic [CLASS_WIDTH-1:0]          r_votes [CLASS_COUNT];
    logic [CLASS_WIDTH-1:0]          r_best_count;
    logic [CLASS_WIDTH-1:0]          r_best_class;
    logic [CLASS_WIDTH-1:0]          r_scan;
    logic [CLASS_WIDTH-1:0]          w_pair_i;
    logic [CLASS_WIDTH-1:0]          w_pair_j;
    logic [DEC_WIDTH-1:0]            w_pair_d;
    logic                            w_pair_last;
    logic [DIST_WIDTH-1:0]           w_dist_sel;
    logic [DIST_WIDTH-1:0]           w_rho_sel;
    logic [DIST_WIDTH:0]             w_margin;
    logic                            w_margin_pos;
    logic [CLASS_WIDTH-1:0]          w_winner;
    logic [CLASS_WIDTH-1:0]          w_scan_cnt;
    logic                            w_scan_last;
    logic                            w_scan_gt;

    svm_pair_counter #(
        .CLASS_COUNT (CLASS_COUNT),
        .CLASS_WIDTH (CLASS_WIDTH),
        .DEC_WIDTH   (DEC_WIDTH)
    ) u_pair (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_step  (r_state == ST_VOTE),
        .o_i     (w_pair_i),
        .o_j     (w_pair_j),
        .o_d     (w_pair_d),
        .o_last  (w_pair_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_dist_valid) w_next_state = ST_VOTE;
            ST_VOTE:   if (w_pair_last)  w_next_state = ST_ARGMAX;
            ST_ARGMAX: if (w_scan_last)  w_next_state = ST_DONE;
            ST_DONE:   if (i_res_ready)  w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decode the state register only, so nothing is combinational
    // from an input.
    always_comb begin
        o_dist_ready = (r_state == ST_IDLE);
        o_res_valid  = (r_state == ST_DONE);
    end

    assign w_accept    = (r_state == ST_IDLE) && i_dist_valid;
    assign o_res_class = r_best_class;

    always_comb begin
        w_dist_sel = '0;
        w_rho_sel  = '0;
        for (int k = 0; k < DEC_COUNT; k++) begin
            if (w_pair_d == DEC_WIDTH'(k)) begin
                w_dist_sel = r_dist[DIST_WIDTH*k +: DIST_WIDTH];
                w_rho_sel  = r_rho[DIST_WIDTH*k +: DIST_WIDTH];
            end
        end
    end

    // Sign-extend by one bit so the difference of extreme operands cannot wrap.
    assign w_margin     = {w_dist_sel[DIST_WIDTH-1], w_dist_sel}
                        - {w_rho_sel[DIST_WIDTH-1], w_rho_sel};
    assign w_margin_pos = !w_margin[DIST_WIDTH] && (w_margin != '0);
    assign w_winner     = w_margin_pos ? w_pair_i : w_pair_j;

    always_comb begin
        w_scan_cnt = '0;
        for (int k = 0; k < CLASS_COUNT; k++) begin
            if (r_scan == CLASS_WIDTH'(k)) w_scan_cnt = r_votes[k];
        end
    end

    assign w_scan_last = (r_scan == CLASS_WIDTH'(CLASS_COUNT - 1));
    assign w_scan_gt   = (w_scan_cnt > r_best_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CLASS_COUNT; k++) r_votes[k] <= '0;
            r_best_count <= '0;
            r_best_class <= '0;
            r_scan       <= '0;
        end else if (w_accept) begin
            r_dist <= i_distance;
            r_rho  <= i_rho;
            for (int k = 0; k < CLASS_COUNT; k++) r_votes[k] <= '0;
            r_scan <= '0;
        end else if (r_state == ST_VOTE) begin
            for (int k = 0; k < CLASS_COUNT; k++) begin
                if (w_winner == CLASS_WIDTH'(k)) r_votes[k] <= r_votes[k] + CLASS_WIDTH'(1);
            end
        end else if (r_state == ST_ARGMAX) begin
            // Class 0 seeds the running best; later classes need strictly more.
            if (r_scan == '0 || w_scan_gt) begin
                r_best_count <= w_scan_cnt;
                r_best_class <= r_scan;
            end
            r_scan <= r_scan + CLASS_WIDTH'(1);
        end
    end

`ifdef SVM_VOTE_TIE_EN
    logic r_tie;
    logic w_scan_eq;

    assign w_scan_eq = (w_scan_cnt == r_best_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tie <= 1'b0;
        end else if (r_state == ST_ARGMAX) begin
            if (r_scan == '0 || w_scan_gt) r_tie <= 1'b0;
            else if (w_scan_eq)            r_tie <= 1'b1;
        end
    end

    assign o_res_tie = r_tie && (r_state == ST_DONE);
`endif

endmodule

// File: tb/tb_svm_vote.sv
// tb_svm_vote: bench for svm_vote with a 3-class and a 4-class instance.
// Expected results come from a behavioural one-vs-one model and are queued
// when a vector is driven, then popped when the instance presents a result.
// Build with SVM_VOTE_TIE_EN defined to also check the tie flag.
module tb_svm_vote;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [DW*3-1:0] d3_distance;
    logic [DW*3-1:0] d3_rho;
    logic            d3_valid;
    logic            d3_ready;
    logic [1:0]      d3_class;
    logic            d3_res_valid;
    logic            d3_res_ready;

    logic [DW*6-1:0] d4_distance;
    logic [DW*6-1:0] d4_rho;
    logic            d4_valid;
    logic            d4_ready;
    logic [1:0]      d4_class;
    logic            d4_res_valid;
    logic            d4_res_ready;

`ifdef SVM_VOTE_TIE_EN
    logic d3_tie;
    logic d4_tie;
`endif

    svm_vote #(.CLASS_COUNT(3), .DIST_WIDTH(DW), .CLASS_WIDTH(2)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .i_distance   (d3_distance),
        .i_rho        (d3_rho),
        .i_dist_valid (d3_valid),
        .o_dist_ready (d3_ready),
        .o_res_class  (d3_class),
        .o_res_valid  (d3_res_valid),
        .i_res_ready  (d3_res_ready)
`ifdef SVM_VOTE_TIE_EN
       ,.o_res_tie    (d3_tie)
`endif
    );

    svm_vote #(.CLASS_COUNT(4), .DIST_WIDTH(DW), .CLASS_WIDTH(2)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .i_distance   (d4_distance),
        .i_rho        (d4_rho),
        .i_dist_valid (d4_valid),
        .o_dist_ready (d4_ready),
        .o_res_class  (d4_class),
        .o_res_valid  (d4_res_valid),
        .i_res_ready  (d4_res_ready)
`ifdef SVM_VOTE_TIE_EN
       ,.o_res_tie    (d4_tie)
`endif
    );

    typedef struct {
        int cls;
        bit tie;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural one-vs-one vote with 64-bit margins.
    function automatic exp_t model(input int c, input int dv[6], input int rv[6]);
        exp_t   e;
        int     votes[4];
        int     d;
        int     best;
        longint m;
        d = 0;
        for (int k = 0; k < 4; k++) votes[k] = 0;
        for (int i = 0; i < c; i++) begin
            for (int j = i + 1; j < c; j++) begin
                m = longint'(dv[d]) - longint'(rv[d]);
                if (m > 0) votes[i]++;
                else       votes[j]++;
                d++;
            end
        end
        best  = -1;
        e.cls = 0;
        e.tie = 1'b0;
        for (int k = 0; k < c; k++) begin
            if (votes[k] > best) begin
                best  = votes[k];
                e.cls = k;
                e.tie = 1'b0;
            end else if (votes[k] == best) begin
                e.tie = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [DW*6-1:0] pack6(input int v[6]);
        logic [DW*6-1:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[DW*k +: DW] = v[k];
        return r;
    endfunction

    task automatic send3(input string name, input int dv[6], input int rv[6]);
        logic [DW*6-1:0] pd;
        logic [DW*6-1:0] pr;
        bit ok;
        pd = pack6(dv);
        pr = pack6(rv);
        q3.push_back(model(3, dv, rv));
        d3_distance = pd[DW*3-1:0];
        d3_rho      = pr[DW*3-1:0];
        d3_valid    = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (d3_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept: dist_ready never high within 200 cycles", name);
        end
        @(posedge clk);
        #1 d3_valid = 1'b0;
    endtask

    // Called right after send3; res_ready is expected high.
    task automatic check_result3(input string name, input int exp_lat);
        int   lat;
        bit   seen;
        bit   rdy_seen;
        exp_t e;
        lat = 0;
        seen = 1'b0;
        rdy_seen = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            if (d3_res_valid) begin
                seen = 1'b1;
                break;
            end
            if (d3_ready) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
        end
        e.cls = 0;
        e.tie = 1'b0;
        if (q3.size() > 0) e = q3.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: res_valid not seen in 100 cycles", name);
            return;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        total++;
        if (rdy_seen !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_ready: got %0b expected 0", name, rdy_seen);
        end
        total++;
        if (int'(d3_class) !== e.cls) begin
            bad++;
            $display("FAIL %s class: got %0d expected %0d", name, d3_class, e.cls);
        end
`ifdef SVM_VOTE_TIE_EN
        total++;
        if (d3_tie !== e.tie) begin
            bad++;
            $display("FAIL %s tie: got %0b expected %0b", name, d3_tie, e.tie);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        d3_valid     = 1'b0;
        d4_valid     = 1'b0;
        d3_distance  = '0;
        d3_rho       = '0;
        d4_distance  = '0;
        d4_rho       = '0;
        d3_res_ready = 1'b1;
        d4_res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (d3_ready !== 1'b1) begin bad++; $display("FAIL reset_ready3: got %0b expected 1", d3_ready); end
        total++;
        if (d3_res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid3: got %0b expected 0", d3_res_valid); end
        total++;
        if (d3_class !== 2'd0) begin bad++; $display("FAIL reset_class3: got %0d expected 0", d3_class); end
        total++;
        if (d4_ready !== 1'b1) begin bad++; $display("FAIL reset_ready4: got %0b expected 1", d4_ready); end
        total++;
        if (d4_res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %0b expected 0", d4_res_valid); end
`ifdef SVM_VOTE_TIE_EN
        total++;
        if (d3_tie !== 1'b0) begin bad++; $display("FAIL reset_tie3: got %0b expected 0", d3_tie); end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_vote3();
        int zr[6];
        int tbl[4][6];
        zr     = '{0, 0, 0, 0, 0, 0};
        tbl[0] = '{5, -3, 7, 0, 0, 0};
        tbl[1] = '{5, 7, -3, 0, 0, 0};
        tbl[2] = '{-1, 5, 3, 0, 0, 0};
        tbl[3] = '{-1, -1, -1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            send3($sformatf("vote3_%0d", k), tbl[k], zr);
            check_result3($sformatf("vote3_%0d", k), 6);
        end
    endtask

    task automatic test_tie();
        int dv[6];
        int rv[6];
        dv = '{4, 4, 4, 0, 0, 0};
        rv = '{4, 0, 10, 0, 0, 0};
        send3("tie3", dv, rv);
        check_result3("tie3", 6);
    endtask

    task automatic test_boundary();
        int dv[6];
        int rv[6];
        dv = '{32'h7FFFFFFF, 0, 5, 0, 0, 0};
        rv = '{32'h80000000, 0, 0, 0, 0, 0};
        send3("bound_pos", dv, rv);
        check_result3("bound_pos", 6);
        dv = '{32'h80000000, 0, 5, 0, 0, 0};
        rv = '{32'h7FFFFFFF, 0, 0, 0, 0, 0};
        send3("bound_neg", dv, rv);
        check_result3("bound_neg", 6);
    endtask

    task automatic test_backpressure();
        int   dv[6];
        int   zr[6];
        bit   seen;
        exp_t e;
        dv = '{5, 7, -3, 0, 0, 0};
        zr = '{0, 0, 0, 0, 0, 0};
        d3_res_ready = 1'b0;
        send3("bp", dv, zr);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (d3_res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        e.cls = 0;
        e.tie = 1'b0;
        if (q3.size() > 0) e = q3.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp timeout: res_valid not seen in 100 cycles");
        end
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            total++;
            if (d3_res_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cycle %0d: got %0b expected 1", n, d3_res_valid); end
            total++;
            if (int'(d3_class) !== e.cls) begin bad++; $display("FAIL bp_hold_class cycle %0d: got %0d expected %0d", n, d3_class, e.cls); end
            total++;
            if (d3_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready cycle %0d: got %0b expected 0", n, d3_ready); end
            @(posedge clk);
        end
        #1 d3_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (d3_res_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %0b expected 0", d3_res_valid); end
        total++;
        if (d3_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b expected 1", d3_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int dv[6];
        int zr[6];
        bit seen;
        dv = '{-1, -1, -1, 0, 0, 0};
        zr = '{0, 0, 0, 0, 0, 0};
        send3("rstmid_abandon", dv, zr);
        void'(q3.pop_back());
        // now in cycle t+1; move to t+3 and hold reset for that cycle
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (d3_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %0b expected 1", d3_ready); end
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (d3_res_valid) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_result: got res_valid=%0b expected 0", seen); end
        @(posedge clk);
        #1;
        dv = '{5, 7, -3, 0, 0, 0};
        send3("rstmid_next", dv, zr);
        check_result3("rstmid_next", 6);
    endtask

    task automatic test_back_to_back();
        int nvec;
        int rcv;
        bit drv_fail;
        nvec = 24;
        rcv = 0;
        drv_fail = 1'b0;
        fork
            begin : driver
                int   dv[6];
                int   rv[6];
                bit   ok;
                logic [DW*6-1:0] pd;
                for (int n = 0; n < nvec; n++) begin
                    for (int k = 0; k < 6; k++) begin
                        dv[k] = int'($urandom_range(0, 40)) - 20;
                        rv[k] = int'($urandom_range(0, 40)) - 20;
                        if ($urandom_range(0, 7) == 0) dv[k] = 32'h7FFFFFFF;
                        if ($urandom_range(0, 7) == 0) rv[k] = 32'h80000000;
                    end
                    q4.push_back(model(4, dv, rv));
                    pd = pack6(dv);
                    d4_distance = pd;
                    pd = pack6(rv);
                    d4_rho = pd;
                    d4_valid = 1'b1;
                    ok = 1'b0;
                    for (int w = 0; w < 300; w++) begin
                        @(negedge clk);
                        if (d4_ready) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    @(posedge clk);
                    #1 d4_valid = 1'b0;
                    if (!ok) begin
                        drv_fail = 1'b1;
                        break;
                    end
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin : consumer
                exp_t e;
                bit   held;
                logic [1:0] held_class;
                held = 1'b0;
                held_class = '0;
                for (int cyc = 0; cyc < 6000 && rcv < nvec && !drv_fail; cyc++) begin
                    @(negedge clk);
                    if (held && d4_res_valid) begin
                        total++;
                        if (d4_class !== held_class) begin
                            bad++;
                            $display("FAIL b2b_stable: got %0d expected %0d", d4_class, held_class);
                        end
                    end
                    held = 1'b0;
                    if (d4_res_valid && !d4_res_ready) begin
                        held = 1'b1;
                        held_class = d4_class;
                    end
                    if (d4_res_valid && d4_res_ready) begin
                        e.cls = -1;
                        e.tie = 1'b0;
                        if (q4.size() > 0) e = q4.pop_front();
                        total++;
                        if (int'(d4_class) !== e.cls) begin
                            bad++;
                            $display("FAIL b2b_class vec %0d: got %0d expected %0d", rcv, d4_class, e.cls);
                        end
`ifdef SVM_VOTE_TIE_EN
                        total++;
                        if (d4_tie !== e.tie) begin
                            bad++;
                            $display("FAIL b2b_tie vec %0d: got %0b expected %0b", rcv, d4_tie, e.tie);
                        end
`endif
                        rcv++;
                    end
                    @(posedge clk);
                    #1 d4_res_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        total++;
        if (rcv !== nvec) begin
            bad++;
            $display("FAIL b2b_count: got %0d results expected %0d", rcv, nvec);
        end
        d4_res_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_vote3();
        test_tie();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
